// File: rtl/ibex_bcp_region_cfg_if.sv
// CSR-side request/response bundle for the BCP region configuration block.
// The master drives table writes, lock and clear requests; the slave answers
// with ready, error and clear-done indications.
interface ibex_bcp_region_cfg_if #(
  parameter int unsigned BCPNumRegions = 4,
  parameter int unsigned XLEN          = 32
);
  localparam int unsigned IdxW = $clog2(BCPNumRegions);

  logic            csr_we_i;
  logic [IdxW-1:0] csr_idx_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic            csr_lock_i;
  logic            clear_req_i;
  logic            csr_ready_o;
  logic            cfg_err_o;
  logic            clear_done_o;

  modport master (
    output csr_we_i, csr_idx_i, csr_wdata_i, csr_lock_i, clear_req_i,
    input  csr_ready_o, cfg_err_o, clear_done_o
  );

  modport slave (
    input  csr_we_i, csr_idx_i, csr_wdata_i, csr_lock_i, clear_req_i,
    output csr_ready_o, cfg_err_o, clear_done_o
  );
endinterface

// File: rtl/ibex_bcp_region_cfg.sv
// BCP region bound table: start/end writes are staged per pair, validated,
// and committed to both entries on one edge while the bound checker is idle.
// Pairs can be locked once valid, and a clear walks all unlocked pairs.
module ibex_bcp_region_cfg #(
  parameter int unsigned BCPNumRegions = 4,
  parameter int unsigned XLEN          = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  ibex_bcp_region_cfg_if.slave               csr_if,
  input  logic                               bcp_busy_i,
  output logic [BCPNumRegions-1:0][XLEN-1:0] csr_bcp_addr_o,
  output logic [BCPNumRegions/2-1:0]         pair_valid_o,
  output logic [BCPNumRegions/2-1:0]         pair_locked_o
);
  localparam int unsigned NP    = BCPNumRegions / 2;
  localparam int unsigned IdxW  = $clog2(BCPNumRegions);
  localparam int unsigned PairW = IdxW - 1;

  typedef enum logic [2:0] {IDLE, STAGED, VALIDATE, COMMIT, CLEAR} state_e;

  state_e                             state_q, state_d;
  logic [PairW-1:0]                   stage_pair_q, stage_pair_d;
  logic [PairW-1:0]                   clr_pair_q, clr_pair_d;
  logic [XLEN-1:0]                    stage_start_q, stage_start_d;
  logic [XLEN-1:0]                    stage_end_q, stage_end_d;
  logic [BCPNumRegions-1:0][XLEN-1:0] table_q, table_d;
  logic [NP-1:0]                      valid_q, valid_d;
  logic [NP-1:0]                      locked_q, locked_d;
  logic                               ready_q, ready_d;
  logic                               err_q, err_d;
  logic                               done_q, done_d;

  logic [PairW-1:0] req_pair;
  logic             req_odd;
  logic             region_ok;

  assign req_pair = csr_if.csr_idx_i[IdxW-1:1];
  assign req_odd  = csr_if.csr_idx_i[0];

  // A staged region is acceptable only if both words share a tag in the
  // 0xC0..0xFE range and the address span is non-decreasing.
  assign region_ok = (stage_start_q[31:24] == stage_end_q[31:24]) &&
                     (stage_start_q[31:30] == 2'b11) &&
                     (stage_start_q[31:24] != 8'hFF) &&
                     (stage_start_q[23:0] <= stage_end_q[23:0]);

  // Next-state, staging, table and pulse computation for every state.
  always_comb begin
    state_d       = state_q;
    stage_pair_d  = stage_pair_q;
    clr_pair_d    = clr_pair_q;
    stage_start_d = stage_start_q;
    stage_end_d   = stage_end_q;
    table_d       = table_q;
    valid_d       = valid_q;
    locked_d      = locked_q;
    err_d         = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (csr_if.csr_we_i) begin
          if (locked_q[req_pair] || req_odd) begin
            err_d = 1'b1;
          end else begin
            stage_start_d = csr_if.csr_wdata_i;
            stage_pair_d  = req_pair;
            state_d       = STAGED;
          end
        end else if (csr_if.csr_lock_i) begin
          if (valid_q[req_pair]) begin
            locked_d[req_pair] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (csr_if.clear_req_i) begin
          clr_pair_d = '0;
          state_d    = CLEAR;
        end
      end

      STAGED: begin
        if (csr_if.csr_we_i) begin
          if (locked_q[req_pair]) begin
            err_d = 1'b1;
          end else if (req_pair == stage_pair_q) begin
            if (req_odd) begin
              stage_end_d = csr_if.csr_wdata_i;
              state_d     = VALIDATE;
            end else begin
              stage_start_d = csr_if.csr_wdata_i;
            end
          end else begin
            err_d = 1'b1;
            if (req_odd) begin
              state_d = IDLE;
            end else begin
              stage_start_d = csr_if.csr_wdata_i;
              stage_pair_d  = req_pair;
            end
          end
        end
      end

      VALIDATE: begin
        if (region_ok) begin
          state_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      COMMIT: begin
        if (!bcp_busy_i) begin
          table_d[{stage_pair_q, 1'b0}] = stage_start_q;
          table_d[{stage_pair_q, 1'b1}] = stage_end_q;
          valid_d[stage_pair_q]         = 1'b1;
          state_d                       = IDLE;
        end
      end

      CLEAR: begin
        if (!bcp_busy_i) begin
          if (!locked_q[clr_pair_q]) begin
            table_d[{clr_pair_q, 1'b0}] = '0;
            table_d[{clr_pair_q, 1'b1}] = '0;
            valid_d[clr_pair_q]         = 1'b0;
          end
          if (clr_pair_q == PairW'(NP - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            clr_pair_d = clr_pair_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == STAGED);
  end

  // All architectural state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      stage_pair_q  <= '0;
      clr_pair_q    <= '0;
      stage_start_q <= '0;
      stage_end_q   <= '0;
      table_q       <= '0;
      valid_q       <= '0;
      locked_q      <= '0;
      ready_q       <= 1'b1;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_pair_q  <= stage_pair_d;
      clr_pair_q    <= clr_pair_d;
      stage_start_q <= stage_start_d;
      stage_end_q   <= stage_end_d;
      table_q       <= table_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign csr_if.csr_ready_o  = ready_q;
  assign csr_if.cfg_err_o    = err_q;
  assign csr_if.clear_done_o = done_q;
  assign csr_bcp_addr_o      = table_q;
  assign pair_valid_o        = valid_q;
  assign pair_locked_o       = locked_q;
endmodule
